// File: rtl/board_init_arbiter.sv
// board_init_arbiter: shares one memory write port between a CPU and a
// board-clear sequencer. The sequencer zeroes CLEAR_START..CLEAR_END and
// then pulses done; the CPU is passed straight through whenever the
// sequencer is not writing.
//
// Optional feature: define BOARD_INIT_TURN_EN to add a TURN step after the
// clear that writes TURN_INIT to TURN_ADDR. Without the macro the sequence
// goes CLEAR -> DONE and TURN is unreachable, so it is trimmed away.
module board_init_arbiter #(
    parameter int SIZE        = 16,
    parameter int DEPTH       = 64,
    parameter int CLEAR_START = 1,
    parameter int CLEAR_END   = 27,
    parameter int TURN_ADDR   = 28,
    parameter int TURN_INIT   = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_start,
    input  logic            cpu_req,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [SIZE-1:0] cpu_data,
    output logic            cpu_ack,
    output logic [AW-1:0]   mem_waddr,
    output logic [SIZE-1:0] mem_write_data,
    output logic            mem_write_en,
    output logic            busy,
    output logic            done
);

`ifdef BOARD_INIT_TURN_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    localparam logic [AW-1:0] CLR_FIRST = AW'(CLEAR_START);
    localparam logic [AW-1:0] CLR_LAST  = AW'(CLEAR_END);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        TURN  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State and clear-address counter; synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= IDLE;
            cnt_q   <= CLR_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and write-port mux; everything forced to zero under reset.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        cpu_ack        = 1'b0;
        mem_write_en   = 1'b0;
        mem_waddr      = '0;
        mem_write_data = '0;
        busy           = 1'b0;
        done           = 1'b0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    mem_write_en   = cpu_req;
                    mem_waddr      = cpu_addr;
                    mem_write_data = cpu_data;
                    cpu_ack        = cpu_req;
                    cnt_d          = CLR_FIRST;
                    if (init_start) begin
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    mem_write_en = 1'b1;
                    mem_waddr    = cnt_q;
                    busy         = 1'b1;
                    if (cnt_q == CLR_LAST) begin
                        state_d = TURN_EN ? TURN : DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
                TURN: begin
                    mem_write_en   = 1'b1;
                    mem_waddr      = AW'(TURN_ADDR);
                    mem_write_data = SIZE'(TURN_INIT);
                    busy           = 1'b1;
                    state_d        = DONE;
                end
                DONE: begin
                    // A CPU write stalled during the clear lands here.
                    mem_write_en   = cpu_req;
                    mem_waddr      = cpu_addr;
                    mem_write_data = cpu_data;
                    cpu_ack        = cpu_req;
                    done           = 1'b1;
                    state_d        = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
